// File: rtl/energy_pkg.sv
// energy_pkg: shared state encoding and default constants for the energy mood regulators.
package energy_pkg;
  typedef enum logic [1:0] {EXHAUSTED, TIRED, NORMAL, ENERGETIC} energy_state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_STEP = 1;
  localparam int DEF_RESET_LEVEL = 128;
  localparam int DEF_T_TIRED = 64;
  localparam int DEF_T_NORMAL = 128;
  localparam int DEF_T_ENERGETIC = 192;
  localparam int DEF_HYST = 8;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..PRESCALE-1 counter, tick high on the last count.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(PRESCALE - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/energy_level_controller.sv
// energy_level_controller: saturating energy integrator with a 4-state hysteretic mood FSM.
// Optional idle decay toward RESET_LEVEL when ENERGY_DECAY_EN is defined.
module energy_level_controller
  import energy_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int STEP = DEF_STEP,
  parameter int RESET_LEVEL = DEF_RESET_LEVEL,
  parameter int T_TIRED = DEF_T_TIRED,
  parameter int T_NORMAL = DEF_T_NORMAL,
  parameter int T_ENERGETIC = DEF_T_ENERGETIC,
  parameter int HYST = DEF_HYST
`ifdef ENERGY_DECAY_EN
  , parameter int DECAY_TICKS = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             energy_inc,
  input  logic             energy_dec,
  output logic [WIDTH-1:0] energy_level,
  output logic [1:0]       energy_state,
  output logic             level_min,
  output logic             level_max,
  output logic             state_changed
);
  localparam logic [WIDTH:0] MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] RST_W = (WIDTH + 1)'(RESET_LEVEL);
  localparam logic [WIDTH-1:0] TT = WIDTH'(T_TIRED);
  localparam logic [WIDTH-1:0] TN = WIDTH'(T_NORMAL);
  localparam logic [WIDTH-1:0] TE = WIDTH'(T_ENERGETIC);
  localparam logic [WIDTH-1:0] TT_DN = WIDTH'(T_TIRED - HYST);
  localparam logic [WIDTH-1:0] TN_DN = WIDTH'(T_NORMAL - HYST);
  localparam logic [WIDTH-1:0] TE_DN = WIDTH'(T_ENERGETIC - HYST);
  logic tick;
  logic [WIDTH:0] wide, up_sum, up, dn, nxt;
  energy_state_t state, ns;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (.clk(clk), .rst(rst), .tick(tick));
  assign wide = {1'b0, energy_level};
  assign up_sum = wide + STEP_W;
  assign up = up_sum > MAX ? MAX : up_sum;
  assign dn = wide < STEP_W ? '0 : wide - STEP_W;
`ifdef ENERGY_DECAY_EN
  localparam int DW = $clog2(DECAY_TICKS + 1);
  logic [DW-1:0] dcnt;
  logic idle, fire;
  logic [WIDTH:0] toward;
  assign idle = !energy_inc && !energy_dec;
  assign fire = idle && dcnt == DW'(DECAY_TICKS - 1);
  assign toward = wide > RST_W ? (dn < RST_W ? RST_W : dn) : (up > RST_W ? RST_W : up);
  always_ff @(posedge clk or posedge rst)
    if (rst) dcnt <= '0;
    else if (tick) dcnt <= (!idle || fire) ? '0 : dcnt + 1'b1;
  always_comb nxt = energy_inc && !energy_dec ? up : energy_dec && !energy_inc ? dn : fire ? toward : wide;
`else
  always_comb nxt = energy_inc && !energy_dec ? up : energy_dec && !energy_inc ? dn : wide;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) energy_level <= RST_W[WIDTH-1:0];
    else if (tick) energy_level <= nxt[WIDTH-1:0];
  // next state looks at the registered level, so the mood trails the level by a cycle
  always_comb begin
    ns = state;
    unique case (state)
      EXHAUSTED: ns = energy_level >= TT ? TIRED : EXHAUSTED;
      TIRED:     ns = energy_level >= TN ? NORMAL : energy_level < TT_DN ? EXHAUSTED : TIRED;
      NORMAL:    ns = energy_level >= TE ? ENERGETIC : energy_level < TN_DN ? TIRED : NORMAL;
      default:   ns = energy_level < TE_DN ? NORMAL : ENERGETIC;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= NORMAL;
      state_changed <= 1'b0;
    end else begin
      state <= ns;
      state_changed <= ns != state;
    end
  assign energy_state = state;
  assign level_min = energy_level == '0;
  assign level_max = &energy_level;
endmodule

// File: tb/tb_energy_level_controller.sv
// tb_energy_level_controller: randomized and directed checks against a behavioural level/mood model.
module tb_energy_level_controller;
  localparam int PS = 4;
  logic clk = 0, rst = 0, inc = 0, dec = 0;
  logic [7:0] energy_level;
  logic [1:0] energy_state;
  logic level_min, level_max, state_changed;
  int passed = 0, total = 0;
  int m_level, m_state, m_cnt, m_chg, m_idle;
  int ol, os, ns;
  int thr[4] = '{0, 64, 128, 192};
  logic [12:0] got, exp;

  energy_level_controller dut (
    .clk(clk), .rst(rst), .energy_inc(inc), .energy_dec(dec),
    .energy_level(energy_level), .energy_state(energy_state),
    .level_min(level_min), .level_max(level_max), .state_changed(state_changed)
  );

  always #5 clk = ~clk;

  always_comb begin
    got = {energy_level, energy_state, state_changed, level_min, level_max};
    exp = {m_level[7:0], m_state[1:0], m_chg[0], m_level == 0, m_level == 255};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 128; m_state = 2; m_chg = 0; m_cnt = 0; m_idle = 0;
    end else begin
      ol = m_level;
      os = m_state;
      if (m_cnt == PS - 1) begin
        if (inc && !dec) m_level = m_level == 255 ? 255 : m_level + 1;
        else if (dec && !inc) m_level = m_level == 0 ? 0 : m_level - 1;
`ifdef ENERGY_DECAY_EN
        if (inc || dec) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == 16) begin
            m_idle = 0;
            if (m_level > 128) m_level--;
            else if (m_level < 128) m_level++;
          end
        end
`endif
      end
      m_cnt = (m_cnt + 1) % PS;
      ns = os;
      if (os < 3 && ol >= thr[os + 1]) ns = os + 1;
      else if (os > 0 && ol < thr[os] - 8) ns = os - 1;
      m_chg = ns != os;
      m_state = ns;
    end
  end

  task automatic test_reset();
    inc = 0; dec = 0;
    @(negedge clk); rst = 1;
    #2;
    total++;
    if ({energy_level, energy_state, state_changed} !== {8'd128, 2'd2, 1'b0})
      $display("FAIL reset_values got=%h want=%h", {energy_level, energy_state, state_changed}, {8'd128, 2'd2, 1'b0});
    else passed++;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp || energy_level !== 8'd128) $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, got, exp);
      else passed++;
    end
  endtask

  task automatic test_inc_climb();
    int pulses = 0;
    inc = 1; dec = 0;
    for (int i = 0; i < 560; i++) begin
      @(negedge clk);
      pulses += state_changed;
      total++;
      if (got !== exp) $display("FAIL inc_climb cyc=%0d got=%h want=%h", i, got, exp);
      else passed++;
    end
    total++;
    if ({energy_level, level_max, energy_state, pulses[3:0]} !== {8'd255, 1'b1, 2'd3, 4'd1})
      $display("FAIL inc_saturate got=%h want=%h", {energy_level, level_max, energy_state, pulses[3:0]}, {8'd255, 1'b1, 2'd3, 4'd1});
    else passed++;
    inc = 0;
  endtask

  task automatic test_dec_fall();
    inc = 0; dec = 1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp) $display("FAIL dec_fall cyc=%0d got=%h want=%h", i, got, exp);
      else passed++;
      if (energy_level >= 8'd184 && energy_level <= 8'd191) begin
        total++;
        if (energy_state !== 2'd3) $display("FAIL hyst_hold lvl=%0d got=%0d want=3", energy_level, energy_state);
        else passed++;
      end
    end
    total++;
    if ({energy_level, level_min, energy_state} !== {8'd0, 1'b1, 2'd0})
      $display("FAIL dec_saturate got=%h want=%h", {energy_level, level_min, energy_state}, {8'd0, 1'b1, 2'd0});
    else passed++;
    dec = 0;
  endtask

  task automatic test_both();
    logic [7:0] lvl0;
    @(negedge clk);
    lvl0 = energy_level;
    inc = 1; dec = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp || energy_level !== lvl0 || state_changed !== 1'b0)
        $display("FAIL both_req cyc=%0d got=%h want=%h lvl0=%0d", i, got, exp, lvl0);
      else passed++;
    end
    inc = 0; dec = 0;
  endtask

  task automatic test_offtick();
    logic [7:0] lvl0;
    @(negedge clk);
    lvl0 = energy_level;
    for (int i = 0; i < 200; i++) begin
      inc = (m_cnt != PS - 1) && $urandom_range(0, 1) == 1;
      @(negedge clk);
      total++;
      if (got !== exp || energy_level !== lvl0) $display("FAIL offtick cyc=%0d got=%h want=%h lvl0=%0d", i, got, exp, lvl0);
      else passed++;
    end
    inc = 0;
  endtask

  task automatic test_rst_mid();
    inc = 1;
    for (int i = 0; i < 8 && m_cnt != PS - 1; i++) @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    total++;
    if ({energy_level, energy_state, state_changed} !== {8'd128, 2'd2, 1'b0})
      $display("FAIL rst_mid got=%h want=%h", {energy_level, energy_state, state_changed}, {8'd128, 2'd2, 1'b0});
    else passed++;
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (got !== exp) $display("FAIL rst_release cyc=%0d got=%h want=%h", i, got, exp);
      else passed++;
    end
    inc = 0;
  endtask

  task automatic test_random();
    int bias;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) bias = $urandom_range(0, 2);
      inc = $urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 2 : 4);
      dec = $urandom_range(0, 9) < (bias == 1 ? 8 : bias == 0 ? 2 : 4);
      rst = $urandom_range(0, 599) == 0;
      @(negedge clk);
      total++;
      if (got !== exp) $display("FAIL random cyc=%0d got=%h want=%h", i, got, exp);
      else passed++;
    end
    rst = 0; inc = 0; dec = 0;
  endtask

  initial begin
    test_reset();
    test_inc_climb();
    test_both();
    test_dec_fall();
    test_offtick();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/energy_level_controller.md
Name: energy_level_controller

Overview:
- Downstream stage of the energy regulator. Consumes its energy_inc / energy_dec request levels.
- Integrates the requests into a saturating energy level and classifies that level into a 4-state discrete energy mood with hysteresis.
- Level and state feed the mood/output logic of the design.

Parameters:
- WIDTH, 8, energy level bit width.
- PRESCALE, 4, clock cycles per update tick; must be >= 1. A value of 1 means every cycle is a tick.
- STEP, 1, level change per tick.
- RESET_LEVEL, 128, level after reset.
- T_TIRED, 64, lower bound of TIRED.
- T_NORMAL, 128, lower bound of NORMAL.
- T_ENERGETIC, 192, lower bound of ENERGETIC.
- HYST, 8, downward hysteresis margin; must be < T_TIRED.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- energy_inc  in  1  increase request (level), from regulator.
- energy_dec  in  1  decrease request (level), from regulator.
- energy_level  out  WIDTH  current saturating level.
- energy_state  out  2  0=EXHAUSTED, 1=TIRED, 2=NORMAL, 3=ENERGETIC.
- level_min  out  1  energy_level == 0.
- level_max  out  1  energy_level == 2^WIDTH-1.
- state_changed  out  1  one-cycle pulse when energy_state changes.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high (clk, rst). All flops clear on rst assertion.
- Reset values:
  - energy_level = RESET_LEVEL.
  - energy_state = NORMAL.
  - state_changed = 0.
  - prescaler = 0.
  - level_min / level_max are decoded from the reset level.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is asserted in the cycle the count equals PRESCALE-1.
- Level update, on a tick only. Inputs are sampled in the tick cycle; requests between ticks are ignored.
  - inc=1, dec=0: level = min(level+STEP, MAX).
  - inc=0, dec=1: level = max(level-STEP, 0).
  - inc=dec=1 or inc=dec=0: level unchanged.
  - Saturating arithmetic uses WIDTH+1 bits internally; no wrap-around.
- State FSM. Evaluated every cycle on the registered level, so it lags the level by one cycle. It moves at most one state per cycle.
  - Up transitions, taken when level >= the upper state's threshold:
    - EXHAUSTED->TIRED at T_TIRED.
    - TIRED->NORMAL at T_NORMAL.
    - NORMAL->ENERGETIC at T_ENERGETIC.
  - Down transitions, taken when level < (the current state's threshold - HYST):
    - ENERGETIC->NORMAL below T_ENERGETIC-HYST.
    - NORMAL->TIRED below T_NORMAL-HYST.
    - TIRED->EXHAUSTED below T_TIRED-HYST.
  - Otherwise the state holds.
- state_changed is registered and high for exactly the cycle in which the new energy_state is first visible.
- level_min and level_max are combinational from the level register.
- rst mid-tick:
  - Prescaler restarts from 0.
  - A pending request is discarded.
  - No state_changed pulse on reset release.

Optional Feature:
- Macro: ENERGY_DECAY_EN.
- Defined:
  - Adds parameter DECAY_TICKS (default 16) and an internal decay counter.
  - After DECAY_TICKS consecutive ticks with inc=dec=0, the level moves STEP toward RESET_LEVEL, without overshoot, and the decay counter clears.
  - Any tick with inc or dec asserted clears the decay counter.
  - A decay step obeys the same saturation rules.
- Undefined:
  - Level holds indefinitely without requests.
  - No decay logic is present.

Decomposition:
- Shared package energy_pkg:
  - energy_state_t enum (EXHAUSTED, TIRED, NORMAL, ENERGETIC).
  - Default threshold and width constants.
- One natural sub-module: tick_prescaler, which takes PRESCALE and outputs a tick pulse. It is reusable by the other mood regulators.

Test Plan:
- Reset with defaults:
  - During rst: level=128, state=NORMAL, state_changed=0.
  - After release, with inc=dec=0 for 100 cycles: level stays 128 (macro undefined).
- Hold inc=1 from 128:
  - Level increments every 4 cycles.
  - state goes to ENERGETIC, with a single state_changed pulse, one cycle after level reaches 192.
  - Level saturates at 255 with level_max=1 and does not wrap.
- Hold dec=1 from 192 (ENERGETIC):
  - State stays ENERGETIC at levels 191..184.
  - State goes to NORMAL when level reaches 183.
  - Continuing down, level saturates at 0 with level_min=1 and state=EXHAUSTED.
- Simultaneous inc=dec=1 for 40 cycles: level is unchanged and state_changed never pulses.
- Requests only off-tick (1-cycle inc pulses placed outside the tick cycle): level is unchanged.
- With ENERGY_DECAY_EN, level=140, idle inputs: level reaches 139 after 16 ticks (64 cycles), then continues down and stops at 128.
